// File: rtl/trap_oldest_collector_pkg.sv
// -----------------------------------------------------------------------------
// trap_oldest_collector_pkg
// Shared core-wide trap definitions used by the oldest-exception collector:
//   - ROB geometry and age tag type ({wrap flag, robIdx})
//   - RISC-V synchronous exception and interrupt cause encodings
//   - trap report record carried from writeback to commit
//   - program-order age comparison helper
//   - fixed interrupt priority list (highest first)
// -----------------------------------------------------------------------------
package trap_oldest_collector_pkg;

    localparam int unsigned ROB_SIZE  = 64;
    localparam int unsigned XLEN      = 64;
    localparam int unsigned ROB_IDX_W = $clog2(ROB_SIZE);
    localparam int unsigned AGE_W     = ROB_IDX_W + 1;
    localparam int unsigned CAUSE_W   = 6;

    typedef logic [AGE_W-1:0] rob_age_t;

    typedef enum logic [CAUSE_W-1:0] {
        EXC_INST_MISALIGN  = 6'd0,
        EXC_INST_FAULT     = 6'd1,
        EXC_ILLEGAL_INST   = 6'd2,
        EXC_BREAKPOINT     = 6'd3,
        EXC_LOAD_MISALIGN  = 6'd4,
        EXC_LOAD_FAULT     = 6'd5,
        EXC_STORE_MISALIGN = 6'd6,
        EXC_STORE_FAULT    = 6'd7,
        EXC_ECALL_U        = 6'd8,
        EXC_ECALL_S        = 6'd9,
        EXC_ECALL_M        = 6'd11,
        EXC_INST_PAGE      = 6'd12,
        EXC_LOAD_PAGE      = 6'd13,
        EXC_STORE_PAGE     = 6'd15
    } exception_e;

    typedef enum logic [3:0] {
        IRQ_S_SOFT  = 4'd1,
        IRQ_M_SOFT  = 4'd3,
        IRQ_S_TIMER = 4'd5,
        IRQ_M_TIMER = 4'd7,
        IRQ_S_EXTER = 4'd9,
        IRQ_M_EXTER = 4'd11
    } interrupt_e;

    typedef struct packed {
        rob_age_t           age;
        exception_e         cause;
        logic [XLEN-1:0]    tval;
    } trap_rpt_t;

    // Highest priority first.
    localparam int unsigned IRQ_NUM = 6;
    localparam interrupt_e IRQ_PRIO [IRQ_NUM] = '{
        IRQ_M_EXTER, IRQ_M_SOFT, IRQ_M_TIMER, IRQ_S_EXTER, IRQ_S_SOFT, IRQ_S_TIMER
    };

    // True when a is strictly older than b. When the wrap flags differ, the
    // uop with the larger index was allocated before the ROB pointer wrapped.
    function automatic logic rob_older(input rob_age_t a, input rob_age_t b);
        if (a[ROB_IDX_W] == b[ROB_IDX_W]) begin
            return a[ROB_IDX_W-1:0] < b[ROB_IDX_W-1:0];
        end
        return a[ROB_IDX_W-1:0] > b[ROB_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/oldest_trap_sel.sv
// -----------------------------------------------------------------------------
// oldest_trap_sel
// Combinational tournament tree that picks the oldest valid trap report.
// On equal ages the lower leaf index wins, so callers place the entry with
// tie priority at leaf 0.
// Ports:
//   leaf_vld_i  in   LEAVES_N        valid per leaf
//   leaf_i      in   LEAVES_N x rpt  report per leaf
//   win_vld_o   out  1               at least one leaf valid
//   win_o       out  rpt             oldest valid report
// -----------------------------------------------------------------------------
module oldest_trap_sel
    import trap_oldest_collector_pkg::*;
#(
    parameter int unsigned LEAVES_N = 5
) (
    input  logic [LEAVES_N-1:0] leaf_vld_i,
    input  trap_rpt_t           leaf_i [LEAVES_N],
    output logic                win_vld_o,
    output trap_rpt_t           win_o
);

    // Pad to a power of two and store the tree heap-style: node i has
    // children 2i+1 and 2i+2, leaves start at PAD-1.
    localparam int unsigned PAD   = 1 << $clog2(LEAVES_N);
    localparam int unsigned NODES = 2 * PAD - 1;

    logic      node_vld [NODES];
    trap_rpt_t node     [NODES];

    always_comb begin
        // NOTE: every element gets a default first so no path leaves a stale value (no latch).
        for (int i = 0; i < int'(NODES); i++) begin
            node_vld[i] = 1'b0;
            node[i]     = '0;
        end
        for (int k = 0; k < int'(LEAVES_N); k++) begin
            node_vld[int'(PAD) - 1 + k] = leaf_vld_i[k];
            node[int'(PAD) - 1 + k]     = leaf_i[k];
        end
        // Right child replaces left only when strictly older, keeping the
        // lower-index tie priority all the way to the root.
        for (int i = int'(PAD) - 2; i >= 0; i--) begin
            if (node_vld[2*i+2] &&
                (!node_vld[2*i+1] || rob_older(node[2*i+2].age, node[2*i+1].age))) begin
                node_vld[i] = 1'b1;
                node[i]     = node[2*i+2];
            end else begin
                node_vld[i] = node_vld[2*i+1];
                node[i]     = node[2*i+1];
            end
        end
    end

    assign win_vld_o = node_vld[0];
    assign win_o     = node[0];

endmodule

// File: rtl/trap_oldest_collector.sv
// -----------------------------------------------------------------------------
// trap_oldest_collector
// Holds the oldest pending exception reported by the writeback channels and
// resolves pending interrupts to one registered highest-priority cause.
// ROB_SIZE and XLEN are core-wide and come from trap_oldest_collector_pkg.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_rpt_*         per-channel fault reports (valid, age, cause, tval)
//   i_squash_vld/age  kill uops strictly younger than the branch age
//   i_flush         drop the held entry and all same-cycle reports
//   i_mip/i_mie/i_irq_gate  interrupt pending, enable and global gate
//   o_exc_*         held exception (registered)
//   o_irq_vld/cause interrupt request and code (registered)
// -----------------------------------------------------------------------------
module trap_oldest_collector
    import trap_oldest_collector_pkg::*;
#(
    parameter int unsigned CHANNELS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         i_rpt_vld,
    input  logic [CHANNELS*AGE_W-1:0]   i_rpt_age,
    input  logic [CHANNELS*CAUSE_W-1:0] i_rpt_cause,
    input  logic [CHANNELS*XLEN-1:0]    i_rpt_tval,
    input  logic                        i_squash_vld,
    input  logic [AGE_W-1:0]            i_squash_age,
    input  logic                        i_flush,
    input  logic [XLEN-1:0]             i_mip,
    input  logic [XLEN-1:0]             i_mie,
    input  logic                        i_irq_gate,
    output logic                        o_exc_vld,
    output logic [AGE_W-1:0]            o_exc_age,
    output logic [CAUSE_W-1:0]          o_exc_cause,
    output logic [XLEN-1:0]             o_exc_tval,
    output logic                        o_irq_vld,
    output logic [XLEN-1:0]             o_irq_cause
);

    localparam int unsigned LEAVES_N = CHANNELS + 1;

    trap_rpt_t             held_q, held_d;
    logic                  held_vld_q, held_vld_d;
    logic                  irq_vld_q, irq_vld_d;
    logic [XLEN-1:0]       irq_cause_q, irq_cause_d;

    logic [LEAVES_N-1:0]   leaf_vld;
    trap_rpt_t             leaf [LEAVES_N];
    logic                  win_vld;
    trap_rpt_t             win;

    // Squash/flush filtering: held entry sits at leaf 0 for tie priority.
    always_comb begin
        leaf_vld[0] = held_vld_q && !i_flush &&
                      !(i_squash_vld && rob_older(i_squash_age, held_q.age));
        leaf[0]     = held_q;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            leaf[c+1].age   = i_rpt_age[c*AGE_W +: AGE_W];
            leaf[c+1].cause = exception_e'(i_rpt_cause[c*CAUSE_W +: CAUSE_W]);
            leaf[c+1].tval  = i_rpt_tval[c*XLEN +: XLEN];
            leaf_vld[c+1]   = i_rpt_vld[c] && !i_flush &&
                              !(i_squash_vld && rob_older(i_squash_age, leaf[c+1].age));
        end
    end

    oldest_trap_sel #(
        .LEAVES_N (LEAVES_N)
    ) u_sel (
        .leaf_vld_i (leaf_vld),
        .leaf_i     (leaf),
        .win_vld_o  (win_vld),
        .win_o      (win)
    );

    // The tree only lets a report beat the held entry when strictly older,
    // so loading the winner never moves the held entry to a younger uop.
    always_comb begin
        held_vld_d = win_vld;
        held_d     = win_vld ? win : held_q;
    end

    // Interrupt resolution: walk lowest to highest priority so the highest
    // pending source is written last. Cause holds while nothing is pending.
    logic [XLEN-1:0] pend;
    logic            unused_pend_bits;

    assign pend             = i_mip & i_mie & {XLEN{i_irq_gate}};
    assign unused_pend_bits = ^pend;

    always_comb begin
        irq_vld_d   = 1'b0;
        irq_cause_d = irq_cause_q;
        for (int p = int'(IRQ_NUM) - 1; p >= 0; p--) begin
            if (pend[IRQ_PRIO[p]]) begin
                irq_vld_d   = 1'b1;
                irq_cause_d = XLEN'(IRQ_PRIO[p]);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the held entry is reset because o_exc_* must read 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_vld_q  <= 1'b0;
            held_q      <= '0;
            irq_vld_q   <= 1'b0;
            irq_cause_q <= '0;
        end else begin
            held_vld_q  <= held_vld_d;
            held_q      <= held_d;
            irq_vld_q   <= irq_vld_d;
            irq_cause_q <= irq_cause_d;
        end
    end

    assign o_exc_vld   = held_vld_q;
    assign o_exc_age   = held_q.age;
    assign o_exc_cause = held_q.cause;
    assign o_exc_tval  = held_q.tval;
    assign o_irq_vld   = irq_vld_q;
    assign o_irq_cause = irq_cause_q;

endmodule

// File: tb/tb_trap_oldest_collector.sv
// -----------------------------------------------------------------------------
// tb_trap_oldest_collector
// Directed vectors with hand-computed expectations for the oldest-exception
// collector and its interrupt priority encoder.
// -----------------------------------------------------------------------------
module tb_trap_oldest_collector;

    localparam int CH    = 4;
    localparam int AW    = 7;
    localparam int CW    = 6;
    localparam int XL    = 64;

    logic                clk;
    logic                rst;
    logic [CH-1:0]       i_rpt_vld;
    logic [CH*AW-1:0]    i_rpt_age;
    logic [CH*CW-1:0]    i_rpt_cause;
    logic [CH*XL-1:0]    i_rpt_tval;
    logic                i_squash_vld;
    logic [AW-1:0]       i_squash_age;
    logic                i_flush;
    logic [XL-1:0]       i_mip;
    logic [XL-1:0]       i_mie;
    logic                i_irq_gate;
    logic                o_exc_vld;
    logic [AW-1:0]       o_exc_age;
    logic [CW-1:0]       o_exc_cause;
    logic [XL-1:0]       o_exc_tval;
    logic                o_irq_vld;
    logic [XL-1:0]       o_irq_cause;

    int checks = 0;
    int errors = 0;

    trap_oldest_collector #(.CHANNELS(CH)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rpt_vld    (i_rpt_vld),
        .i_rpt_age    (i_rpt_age),
        .i_rpt_cause  (i_rpt_cause),
        .i_rpt_tval   (i_rpt_tval),
        .i_squash_vld (i_squash_vld),
        .i_squash_age (i_squash_age),
        .i_flush      (i_flush),
        .i_mip        (i_mip),
        .i_mie        (i_mie),
        .i_irq_gate   (i_irq_gate),
        .o_exc_vld    (o_exc_vld),
        .o_exc_age    (o_exc_age),
        .o_exc_cause  (o_exc_cause),
        .o_exc_tval   (o_exc_tval),
        .o_irq_vld    (o_irq_vld),
        .o_irq_cause  (o_irq_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Clear the per-cycle exception stimulus (interrupt inputs are left alone).
    task automatic clear_exc();
        i_rpt_vld    = '0;
        i_rpt_age    = '0;
        i_rpt_cause  = '0;
        i_rpt_tval   = '0;
        i_squash_vld = 1'b0;
        i_squash_age = '0;
        i_flush      = 1'b0;
    endtask

    task automatic report(input int ch, input logic flag, input logic [5:0] idx,
                          input logic [5:0] cause, input logic [63:0] tval);
        i_rpt_vld[ch]            = 1'b1;
        i_rpt_age[ch*AW +: AW]   = {flag, idx};
        i_rpt_cause[ch*CW +: CW] = cause;
        i_rpt_tval[ch*XL +: XL]  = tval;
    endtask

    // Apply the staged inputs on one clock edge, then drop them and settle.
    task automatic step();
        @(posedge clk);
        #1;
        clear_exc();
    endtask

    task automatic do_flush();
        i_flush = 1'b1;
        step();
    endtask

    initial begin
        rst        = 1'b1;
        i_mip      = '0;
        i_mie      = '0;
        i_irq_gate = 1'b0;
        clear_exc();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_exc_vld",   64'(o_exc_vld),   64'd0);
        check("rst_exc_age",   64'(o_exc_age),   64'd0);
        check("rst_exc_cause", 64'(o_exc_cause), 64'd0);
        check("rst_exc_tval",  o_exc_tval,       64'd0);
        check("rst_irq_vld",   64'(o_irq_vld),   64'd0);
        check("rst_irq_cause", o_irq_cause,      64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single report on ch2, visible one cycle later
        report(2, 1'b0, 6'd5, 6'd5, 64'h80);
        #1;
        check("single_latency_vld", 64'(o_exc_vld), 64'd0);
        step();
        check("single_vld",   64'(o_exc_vld),   64'd1);
        check("single_age",   64'(o_exc_age),   64'h05);
        check("single_cause", 64'(o_exc_cause), 64'd5);
        check("single_tval",  o_exc_tval,       64'h80);
        step();
        check("single_hold",  64'(o_exc_age),   64'h05);

        // Multi-channel: oldest age 3 on ch1 and ch3, lowest channel wins
        do_flush();
        check("flush_clear_vld", 64'(o_exc_vld), 64'd0);
        report(0, 1'b0, 6'd9, 6'd1, 64'h99);
        report(1, 1'b0, 6'd3, 6'd2, 64'h11);
        report(3, 1'b0, 6'd3, 6'd4, 64'h33);
        step();
        check("multi_age",   64'(o_exc_age),   64'h03);
        check("multi_cause", 64'(o_exc_cause), 64'd2);
        check("multi_tval",  o_exc_tval,       64'h11);
        report(0, 1'b0, 6'd4, 6'd7, 64'h44);
        step();
        check("younger_ignored_age",   64'(o_exc_age),   64'h03);
        check("younger_ignored_cause", 64'(o_exc_cause), 64'd2);
        report(0, 1'b0, 6'd3, 6'd6, 64'h66);
        step();
        check("equal_held_wins", 64'(o_exc_cause), 64'd2);
        report(2, 1'b0, 6'd2, 6'd13, 64'h22);
        step();
        check("older_replaces_age",   64'(o_exc_age),   64'h02);
        check("older_replaces_cause", 64'(o_exc_cause), 64'd13);

        // Wrap-around ordering
        do_flush();
        report(0, 1'b0, 6'd62, 6'd1, 64'h62);
        step();
        report(1, 1'b1, 6'd1, 6'd2, 64'h101);
        step();
        check("wrap_keep_old", 64'(o_exc_age), 64'h3E);
        do_flush();
        report(1, 1'b1, 6'd1, 6'd2, 64'h101);
        step();
        check("wrap_load_new", 64'(o_exc_age), 64'h41);
        report(0, 1'b0, 6'd62, 6'd1, 64'h62);
        step();
        check("wrap_replace_age",  64'(o_exc_age), 64'h3E);
        check("wrap_replace_tval", o_exc_tval,     64'h62);

        // Squash
        do_flush();
        report(0, 1'b0, 6'd20, 6'd5, 64'h20);
        step();
        check("sq_setup_vld", 64'(o_exc_vld), 64'd1);
        i_squash_vld = 1'b1;
        i_squash_age = {1'b0, 6'd20};
        step();
        check("sq_equal_keeps_vld", 64'(o_exc_vld), 64'd1);
        check("sq_equal_keeps_age", 64'(o_exc_age), 64'h14);
        i_squash_vld = 1'b1;
        i_squash_age = {1'b0, 6'd10};
        report(1, 1'b0, 6'd12, 6'd4, 64'h12);
        step();
        check("sq_kill_vld", 64'(o_exc_vld), 64'd0);
        i_squash_vld = 1'b1;
        i_squash_age = {1'b0, 6'd10};
        report(3, 1'b0, 6'd8, 6'd7, 64'h08);
        step();
        check("sq_older_rpt_vld", 64'(o_exc_vld), 64'd1);
        check("sq_older_rpt_age", 64'(o_exc_age), 64'h08);

        // Flush beats a same-cycle report
        do_flush();
        i_flush = 1'b1;
        report(0, 1'b0, 6'd1, 6'd3, 64'h1);
        step();
        check("flush_vs_rpt_vld", 64'(o_exc_vld), 64'd0);

        // Interrupts
        i_mip      = 64'h0000_0000_0000_02A0;   // bits 5,7,9
        i_mie      = 64'h0000_0000_0000_02A0;
        i_irq_gate = 1'b1;
        #1;
        check("irq_latency_vld", 64'(o_irq_vld), 64'd0);
        step();
        check("irq_mtimer_vld",   64'(o_irq_vld), 64'd1);
        check("irq_mtimer_cause", o_irq_cause,    64'd7);
        i_mip = 64'h0000_0000_0000_0AA0;        // add bit 11
        i_mie = 64'h0000_0000_0000_0AA0;
        i_flush = 1'b1;
        step();
        check("irq_mexter_flush_cause", o_irq_cause, 64'd11);
        i_mie = 64'h0000_0000_0000_0002;        // enabled bit not pending
        step();
        check("irq_mie_mask_vld",   64'(o_irq_vld), 64'd0);
        check("irq_mie_mask_cause", o_irq_cause,    64'd11);
        i_mip = 64'h0000_0000_0000_0022;        // bits 1,5
        i_mie = 64'h0000_0000_0000_0022;
        step();
        check("irq_ssoft_cause", o_irq_cause, 64'd1);
        i_irq_gate = 1'b0;
        step();
        check("irq_gate_off_vld",   64'(o_irq_vld), 64'd0);
        check("irq_gate_off_cause", o_irq_cause,    64'd1);

        // Async reset mid-run
        i_irq_gate = 1'b1;
        report(2, 1'b0, 6'd30, 6'd5, 64'hAB);
        step();
        check("pre_rst_exc_vld", 64'(o_exc_vld), 64'd1);
        check("pre_rst_irq_vld", 64'(o_irq_vld), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_exc_vld",   64'(o_exc_vld),   64'd0);
        check("async_rst_exc_age",   64'(o_exc_age),   64'd0);
        check("async_rst_exc_tval",  o_exc_tval,       64'd0);
        check("async_rst_irq_vld",   64'(o_irq_vld),   64'd0);
        check("async_rst_irq_cause", o_irq_cause,      64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("post_rst_irq_vld", 64'(o_irq_vld), 64'd1);
        check("post_rst_exc_vld", 64'(o_exc_vld), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
